// File: rtl/stream_burst_drain.sv
// Burst-oriented read side of a StreamingFIFO: pops whole bursts (or a timed-out
// partial flush) and re-emits them as AXI-Stream with TLAST on the final beat.
module stream_burst_drain #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned COUNT_W   = 14,
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [COUNT_W-1:0] fifo_count,
    input  logic [WIDTH-1:0]   in0_V_V_TDATA,
    input  logic               in0_V_V_TVALID,
    output logic               in0_V_V_TREADY,
    output logic [WIDTH-1:0]   out_V_V_TDATA,
    output logic               out_V_V_TVALID,
    input  logic               out_V_V_TREADY,
    output logic               out_V_V_TLAST,
    output logic               busy
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [COUNT_W-1:0] BURST_LEN_C = COUNT_W'(BURST_LEN);
    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(TIMEOUT - 1);
    localparam bit                 TMO_EN      = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FLUSH
    } state_t;

    state_t             state, state_nx;
    logic [COUNT_W-1:0] beats_left, beats_left_nx;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nx;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               in_ready;
    logic               in_hs;
    logic               out_hs;
    logic               tmo_flush;
    logic               last_beat;

    // Single output register: pop only when it is empty or draining this cycle.
    assign in_ready  = (state != IDLE) && (!out_valid_q || out_V_V_TREADY);
    assign in_hs     = in_ready && in0_V_V_TVALID;
    assign out_hs    = out_valid_q && out_V_V_TREADY;
    assign last_beat = (beats_left == COUNT_W'(1));
    assign tmo_flush = TMO_EN && (fifo_count != '0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nx      = state;
        beats_left_nx = beats_left;
        tmo_cnt_nx    = tmo_cnt;
        case (state)
            IDLE: begin
                if (fifo_count >= BURST_LEN_C) begin
                    state_nx      = BURST;
                    beats_left_nx = BURST_LEN_C;
                    tmo_cnt_nx    = '0;
                end else if (tmo_flush) begin
                    state_nx      = FLUSH;
                    beats_left_nx = fifo_count;
                    tmo_cnt_nx    = '0;
                end else if (fifo_count != '0) begin
                    tmo_cnt_nx = tmo_cnt + TMO_W'(1);
                end else begin
                    tmo_cnt_nx = '0;
                end
            end
            BURST, FLUSH: begin
                if (in_hs) begin
                    beats_left_nx = beats_left - COUNT_W'(1);
                    if (last_beat) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            beats_left <= '0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nx;
            beats_left <= beats_left_nx;
            tmo_cnt    <= tmo_cnt_nx;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (in_hs) begin
            out_data_q  <= in0_V_V_TDATA;
            out_valid_q <= 1'b1;
            out_last_q  <= last_beat;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign in0_V_V_TREADY = in_ready;
    assign out_V_V_TDATA  = out_data_q;
    assign out_V_V_TVALID = out_valid_q;
    assign out_V_V_TLAST  = out_last_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_stream_burst_drain.sv
// Directed bench for stream_burst_drain: FIFO model on the read side, beat
// capture on the output side, one task per scenario.
module tb_stream_burst_drain;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned COUNT_W = 14;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [COUNT_W-1:0] fifo_count;
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               out_last;
    logic               busy;

    logic [COUNT_W-1:0] nt_count;
    logic [WIDTH-1:0]   nt_in_data;
    logic               nt_in_valid;
    logic               nt_in_ready;
    logic [WIDTH-1:0]   nt_out_data;
    logic               nt_out_valid;
    logic               nt_out_ready;
    logic               nt_out_last;
    logic               nt_busy;

    stream_burst_drain #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .BURST_LEN(256), .TIMEOUT(1024)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .fifo_count(fifo_count),
        .in0_V_V_TDATA(in_data), .in0_V_V_TVALID(in_valid), .in0_V_V_TREADY(in_ready),
        .out_V_V_TDATA(out_data), .out_V_V_TVALID(out_valid), .out_V_V_TREADY(out_ready),
        .out_V_V_TLAST(out_last), .busy(busy)
    );

    // Flush-disabled instance fed a constant 5-beat occupancy.
    assign nt_count     = 14'd5;
    assign nt_in_data   = 8'h5A;
    assign nt_in_valid  = 1'b1;
    assign nt_out_ready = 1'b1;

    stream_burst_drain #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .BURST_LEN(256), .TIMEOUT(0)) dut_nt (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .fifo_count(nt_count),
        .in0_V_V_TDATA(nt_in_data), .in0_V_V_TVALID(nt_in_valid), .in0_V_V_TREADY(nt_in_ready),
        .out_V_V_TDATA(nt_out_data), .out_V_V_TVALID(nt_out_valid), .out_V_V_TREADY(nt_out_ready),
        .out_V_V_TLAST(nt_out_last), .busy(nt_busy)
    );

    logic [WIDTH-1:0]   mem [0:16383];
    logic [COUNT_W-1:0] rd_ptr = '0;
    logic [COUNT_W-1:0] wr_ptr = '0;

    assign fifo_count = wr_ptr - rd_ptr;
    assign in_valid   = (fifo_count != '0);
    assign in_data    = mem[rd_ptr];

    always @(posedge ap_clk) begin
        if (in_ready && in_valid) rd_ptr <= rd_ptr + 14'd1;
    end

    int unsigned      nbeat = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] cap_data [0:4095];
    logic             cap_last [0:4095];
    int               cap_cyc  [0:4095];

    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) begin
            cap_data[nbeat] <= out_data;
            cap_last[nbeat] <= out_last;
            cap_cyc[nbeat]  <= cyc;
            nbeat           <= nbeat + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic push(input int n, input logic [WIDTH-1:0] first);
        for (int i = 0; i < n; i++) mem[wr_ptr + 14'(i)] = 8'(first + 8'(i));
        wr_ptr = wr_ptr + 14'(n);
    endtask

    task automatic wait_beats(input int unsigned target, input int budget, output bit ok);
        int n = 0;
        while (nbeat < target && n < budget) begin
            @(negedge ap_clk);
            n++;
        end
        ok = (nbeat >= target);
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge ap_clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", out_last); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", out_data); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        ap_rst_n = 1'b1;
        repeat (5) @(negedge ap_clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL idle_empty busy=%b in_ready=%b exp=0/0", busy, in_ready);
        end
    endtask

    task automatic test_full_burst();
        int unsigned base = nbeat;
        int errs = 0, lasts = 0, gaps = 0;
        bit ok;
        out_ready = 1'b1;
        push(256, 8'h00);
        @(negedge ap_clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL burst_busy_rise got=%b exp=1", busy); end
        wait_beats(base + 256, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL burst_timeout beats=%0d exp=256", nbeat - base); end
        for (int i = 0; i < 256; i++) begin
            if (cap_data[base+i] !== 8'(i)) errs++;
            if (cap_last[base+i] === 1'b1) lasts++;
            if (i > 0 && cap_cyc[base+i] != cap_cyc[base+i-1] + 1) gaps++;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL burst_data bad_beats=%0d exp=0", errs); end
        checks++; if (lasts != 1 || cap_last[base+255] !== 1'b1) begin
            failures++; $display("FAIL burst_tlast count=%0d final=%b exp=1/1", lasts, cap_last[base+255]);
        end
        checks++; if (gaps != 0) begin failures++; $display("FAIL burst_gaps got=%0d exp=0", gaps); end
        repeat (3) @(negedge ap_clk);
        checks++; if (busy !== 1'b0 || nbeat != base + 256) begin
            failures++; $display("FAIL burst_end busy=%b beats=%0d exp=0/256", busy, nbeat - base);
        end
    endtask

    task automatic test_timeout_flush();
        int unsigned base = nbeat;
        int pops = 0, errs = 0, lasts = 0;
        bit ok;
        out_ready = 1'b1;
        push(10, 8'hA0);
        repeat (1023) begin
            @(negedge ap_clk);
            if (in_ready) pops++;
        end
        checks++; if (pops != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL flush_early pops=%0d busy=%b exp=0/0", pops, busy);
        end
        @(negedge ap_clk);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_start busy=%b in_ready=%b exp=1/1", busy, in_ready);
        end
        wait_beats(base + 10, 30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL flush_timeout beats=%0d exp=10", nbeat - base); end
        for (int i = 0; i < 10; i++) begin
            if (cap_data[base+i] !== 8'(8'hA0 + 8'(i))) errs++;
            if (cap_last[base+i] === 1'b1) lasts++;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL flush_data bad_beats=%0d exp=0", errs); end
        checks++; if (lasts != 1 || cap_last[base+9] !== 1'b1) begin
            failures++; $display("FAIL flush_tlast count=%0d final=%b exp=1/1", lasts, cap_last[base+9]);
        end
        repeat (5) @(negedge ap_clk);
        checks++; if (nbeat != base + 10 || busy !== 1'b0) begin
            failures++; $display("FAIL flush_end beats=%0d busy=%b exp=10/0", nbeat - base, busy);
        end
    endtask

    task automatic test_backpressure();
        int unsigned base = nbeat;
        bit [3:0] pat = 4'b1001;
        logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
        logic [WIDTH-1:0] prev_d = '0;
        int unstable = 0, errs = 0, lasts = 0, k = 0;
        out_ready = 1'b1;
        push(256, 8'h40);
        while (nbeat < base + 256 && k < 3000) begin
            @(negedge ap_clk);
            if (prev_v && !prev_r) begin
                if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) unstable++;
            end
            prev_v = out_valid; prev_d = out_data; prev_l = out_last;
            out_ready = pat[k % 4];
            prev_r = out_ready;
            k++;
        end
        out_ready = 1'b1;
        checks++; if (nbeat < base + 256) begin failures++; $display("FAIL bp_timeout beats=%0d exp=256", nbeat - base); end
        checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable violations=%0d exp=0", unstable); end
        for (int i = 0; i < 256; i++) begin
            if (cap_data[base+i] !== 8'(8'h40 + 8'(i))) errs++;
            if (cap_last[base+i] === 1'b1) lasts++;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL bp_data bad_beats=%0d exp=0", errs); end
        checks++; if (lasts != 1 || cap_last[base+255] !== 1'b1) begin
            failures++; $display("FAIL bp_tlast count=%0d final=%b exp=1/1", lasts, cap_last[base+255]);
        end
        repeat (4) @(negedge ap_clk);
        checks++; if (nbeat != base + 256 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_end beats=%0d busy=%b exp=256/0", nbeat - base, busy);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned base = nbeat;
        int errs = 0, lasts = 0, bad_last = 0;
        bit ok;
        out_ready = 1'b1;
        push(600, 8'h00);
        wait_beats(base + 600, 2500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout beats=%0d exp=600", nbeat - base); end
        for (int i = 0; i < 600; i++) begin
            if (cap_data[base+i] !== 8'(i)) errs++;
            if (cap_last[base+i] === 1'b1) begin
                lasts++;
                if (i != 255 && i != 511 && i != 599) bad_last++;
            end
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL b2b_data bad_beats=%0d exp=0", errs); end
        checks++; if (lasts != 3 || bad_last != 0) begin
            failures++; $display("FAIL b2b_tlast count=%0d misplaced=%0d exp=3/0", lasts, bad_last);
        end
        checks++; if (cap_cyc[base+256] - cap_cyc[base+255] != 2) begin
            failures++; $display("FAIL b2b_gap got=%0d exp=2", cap_cyc[base+256] - cap_cyc[base+255]);
        end
        checks++; if (cap_cyc[base+512] - cap_cyc[base+511] != 1025) begin
            failures++; $display("FAIL b2b_flush_delay got=%0d exp=1025", cap_cyc[base+512] - cap_cyc[base+511]);
        end
        repeat (4) @(negedge ap_clk);
        checks++; if (nbeat != base + 600 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_end beats=%0d busy=%b exp=600/0", nbeat - base, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        int unsigned base = nbeat;
        int unsigned nb0;
        int k = 0, act = 0, need, errs = 0, lasts = 0;
        bit ok;
        out_ready = 1'b1;
        push(256, 8'h10);
        while (nbeat < base + 100 && k < 400) begin
            @(negedge ap_clk);
            k++;
        end
        checks++; if (nbeat < base + 100) begin failures++; $display("FAIL rmb_reach beats=%0d exp=100", nbeat - base); end
        @(posedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL rmb_async_out valid=%b last=%b data=%h exp=0/0/00", out_valid, out_last, out_data);
        end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rmb_async_ctl in_ready=%b busy=%b exp=0/0", in_ready, busy);
        end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        nb0 = nbeat;
        repeat (50) begin
            @(negedge ap_clk);
            if (busy || in_ready) act++;
        end
        checks++; if (act != 0 || nbeat != nb0) begin
            failures++; $display("FAIL rmb_idle active=%0d beats=%0d exp=0/0", act, nbeat - nb0);
        end
        need = 256 - int'(fifo_count);
        push(need, 8'h10);
        wait_beats(nb0 + 256, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmb_timeout beats=%0d exp=256", nbeat - nb0); end
        for (int i = 0; i < 256; i++) begin
            if (i > 0 && cap_data[nb0+i] !== 8'(cap_data[nb0+i-1] + 8'd1)) errs++;
            if (cap_last[nb0+i] === 1'b1) lasts++;
        end
        checks++; if (errs != 0 || cap_data[nb0+255] !== 8'(8'h0F + 8'(need))) begin
            failures++; $display("FAIL rmb_data bad=%0d final=%h exp=0/%h", errs, cap_data[nb0+255], 8'(8'h0F + 8'(need)));
        end
        checks++; if (lasts != 1 || cap_last[nb0+255] !== 1'b1) begin
            failures++; $display("FAIL rmb_tlast count=%0d final=%b exp=1/1", lasts, cap_last[nb0+255]);
        end
        repeat (4) @(negedge ap_clk);
    endtask

    task automatic test_timeout_disabled();
        int rdy = 0, bsy = 0, vld = 0;
        repeat (5000) begin
            @(negedge ap_clk);
            if (nt_in_ready) rdy++;
            if (nt_busy) bsy++;
            if (nt_out_valid) vld++;
        end
        checks++; if (rdy != 0) begin failures++; $display("FAIL nt_in_ready high_cycles=%0d exp=0", rdy); end
        checks++; if (bsy != 0) begin failures++; $display("FAIL nt_busy high_cycles=%0d exp=0", bsy); end
        checks++; if (vld != 0) begin failures++; $display("FAIL nt_out_valid high_cycles=%0d exp=0", vld); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_burst();
        test_timeout_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        test_timeout_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
